// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative unsigned multiply and restoring divide behind valid/ready handshakes.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_DIVU  = 4'd11;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
    logic [CW-1:0]    cnt_q;

    logic             accept, is_long;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_out, sc_sum, sc_diff;
    logic             sc_ovf, sc_zero, sc_known;

    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] acc_hi_d, acc_lo_d;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign is_long   = (alu_ctrl == OP_MULTU) || (alu_ctrl == OP_DIVU);
    assign a_s       = input_1;
    assign b_s       = input_2;
    assign shamt     = input_2[SHW-1:0];

    always_comb begin
        sc_out   = '0;
        sc_ovf   = 1'b0;
        sc_known = 1'b1;
        sc_sum   = input_1 + input_2;
        sc_diff  = input_1 - input_2;
        case (alu_ctrl)
            4'd0:  sc_out = input_1 & input_2;
            4'd1:  sc_out = input_1 | input_2;
            4'd2: begin
                sc_out = sc_sum;
                sc_ovf = (input_1[WIDTH-1] == input_2[WIDTH-1]) &&
                         (sc_sum[WIDTH-1] != input_1[WIDTH-1]);
            end
            4'd3:  sc_out = input_1 ^ input_2;
            4'd4:  sc_out = input_1 << shamt;
            4'd5:  sc_out = input_1 >> shamt;
            4'd6: begin
                sc_out = sc_diff;
                sc_ovf = (input_1[WIDTH-1] != input_2[WIDTH-1]) &&
                         (sc_diff[WIDTH-1] != input_1[WIDTH-1]);
            end
            4'd7:  sc_out = WIDTH'(input_1 < input_2);
            4'd8:  sc_out = WIDTH'(a_s < b_s);
            4'd9:  sc_out = $unsigned(a_s >>> shamt);
            4'd12: sc_out = ~(input_1 | input_2);
            default: sc_known = 1'b0;
        endcase
        // Undefined opcodes report every output low, including the zero flag
        sc_zero = sc_known && (sc_out == '0);
    end

    // One iteration: shift-add multiply, or restoring shift-subtract divide
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        if (op_q == OP_MULTU) begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = is_long ? CALC : DONE;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            alu_out  <= '0;
            alu_hi   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            op_q     <= alu_ctrl;
            cnt_q    <= CW'(WIDTH - 1);
            acc_hi_q <= '0;
            if (alu_ctrl == OP_MULTU) begin
                opnd_q   <= input_1;
                acc_lo_q <= input_2;
            end else begin
                opnd_q   <= input_2;
                acc_lo_q <= input_1;
            end
            if (!is_long) begin
                alu_out  <= sc_out;
                alu_hi   <= '0;
                zero     <= sc_zero;
                overflow <= sc_ovf;
                div_zero <= 1'b0;
            end
        end else if (state_q == CALC) begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                alu_out  <= acc_lo_d;
                alu_hi   <= acc_hi_d;
                zero     <= (acc_lo_d == '0);
                overflow <= 1'b0;
                div_zero <= (op_q == OP_DIVU) && (opnd_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=32) with immediate-assertion checks.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] input_1, input_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out, alu_hi;
    logic        zero, overflow, div_zero;

    int total  = 0;
    int passed = 0;

    alu_multicycle #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .input_1(input_1), .input_2(input_2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .alu_hi(alu_hi),
        .zero(zero), .overflow(overflow), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present a request at a negedge, let it be accepted, then count negedges
    // until out_valid (1 = visible in the cycle right after the accept edge).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_valid, output int lat, output bit busy_ok);
        @(negedge clk);
        alu_ctrl = op; input_1 = a; input_2 = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int lat;
    bit busy_ok;
    bit stable;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; input_1 = '0; input_2 = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_in_ready", in_ready, 1);
        chk("init_out_valid", out_valid, 0);

        // ADD overflow, leaves nonzero results in the output registers
        do_op(4'd2, 32'h7FFF_FFFF, 32'h1, 0, lat, busy_ok);
        chk("add_lat", lat, 1);
        chk("add_out", alu_out, 32'h8000_0000);
        chk("add_ovf", overflow, 1);
        chk("add_zero", zero, 0);
        chk("add_hi", alu_hi, 0);
        take_result();

        // Start a MULTU and abort it with reset
        @(negedge clk);
        alu_ctrl = 4'd10; input_1 = 32'hFFFF_FFFF; input_2 = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_mul_in_ready", in_ready, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_alu_hi", alu_hi, 0);
        chk("rst_flags", {zero, overflow, div_zero}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        do_op(4'd6, 32'd5, 32'd5, 0, lat, busy_ok);
        chk("sub_lat", lat, 1);
        chk("sub_out", alu_out, 0);
        chk("sub_zero", zero, 1);
        chk("sub_ovf", overflow, 0);
        take_result();

        do_op(4'd8, 32'hFFFF_FFFF, 32'h1, 0, lat, busy_ok);
        chk("slt_out", alu_out, 1);
        take_result();
        do_op(4'd7, 32'hFFFF_FFFF, 32'h1, 0, lat, busy_ok);
        chk("sltu_out", alu_out, 0);
        take_result();
        do_op(4'd9, 32'h8000_0000, 32'd4, 0, lat, busy_ok);
        chk("sra_out", alu_out, 32'hF800_0000);
        take_result();
        do_op(4'd12, 32'h0F0F_0000, 32'h0000_00F0, 0, lat, busy_ok);
        chk("nor_out", alu_out, 32'hF0F0_FF0F);
        take_result();

        do_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, busy_ok);
        chk("mul_lat", lat, 33);
        chk("mul_busy", busy_ok, 1);
        chk("mul_hi", alu_hi, 32'hFFFF_FFFE);
        chk("mul_out", alu_out, 32'h0000_0001);
        take_result();

        do_op(4'd11, 32'd100, 32'd7, 0, lat, busy_ok);
        chk("div_lat", lat, 33);
        chk("div_q", alu_out, 32'd14);
        chk("div_r", alu_hi, 32'd2);
        chk("div_dz", div_zero, 0);
        take_result();

        do_op(4'd11, 32'd9, 32'd0, 0, lat, busy_ok);
        chk("div0_lat", lat, 33);
        chk("div0_q", alu_out, 32'hFFFF_FFFF);
        chk("div0_r", alu_hi, 32'd9);
        chk("div0_dz", div_zero, 1);
        take_result();

        // Backpressure: XOR result held while a new AND request waits
        do_op(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, lat, busy_ok);
        chk("xor_dz_clear", div_zero, 0);
        alu_ctrl = 4'd0; input_1 = 32'h1234_5678; input_2 = 32'h0000_FFFF;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 32'h0FF0_0FF0 ||
                alu_hi !== 32'h0) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_out", alu_out, 32'h0000_5678);
        take_result();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
